datapath_unit: RTL and testbench

4-bit accumulator datapath executing the 8-bit instruction stream issued by the control unit, one instruction per clock while running. Holds accumulator, B register, carry/zero flags and an output latch. Whenever the control unit presents a control-flow instruction, it returns the flag status to the control unit over the shared 4-bit tri-state bus. This lets the control unit resolve JNZ.

---
 rtl/datapath_unit.sv | 164 ++++++++++++++++
 tb/tb_datapath_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_unit.sv
// datapath_unit
//   4-bit accumulator datapath that executes one 8-bit instruction per clock
//   while the control unit holds `state` high. It contains the accumulator,
//   the B register, the carry and zero flags, and an output latch with a
//   one-cycle strobe. On a control-flow instruction it drives the flags onto
//   the shared bus. The control unit uses them to resolve JNZ.
//
// Ports
//   clk      : system clock, rising-edge active
//   rst      : asynchronous active-low reset
//   state    : run enable; 0 holds all state
//   instr    : {op[2], op[1:0], cf, imm[3:0]}
//   bus      : shared 4-bit tri-state bus; driven only in status cycles
//   acc      : accumulator (registered)
//   zero     : zero flag (registered)
//   carry    : carry / borrow flag (registered)
//   out_data : output latch
//   out_stb  : one-cycle pulse after out_data is written
module datapath_unit #(
  parameter int ZERO_BIT  = 0,
  parameter int CARRY_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       state,
  input  logic [7:0] instr,
  inout  wire  [3:0] bus,
  output logic [3:0] acc,
  output logic       zero,
  output logic       carry,
  output logic [3:0] out_data,
  output logic       out_stb
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MOVB = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_ADDB = 3'b111;

  logic [3:0] imm;
  logic       cf;
  logic [2:0] op;

  assign imm = instr[3:0];
  assign cf  = instr[4];
  assign op  = {instr[7], instr[6:5]};

  logic [3:0] acc_q, acc_d;
  logic [3:0] b_q, b_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;
  logic [3:0] out_data_q, out_data_d;
  logic       out_stb_q, out_stb_d;

  // Five-bit results. Bit 4 is the carry-out for additions. For the
  // subtraction it is the borrow, which is set exactly when imm > acc.
  logic [4:0] sum_imm;
  logic [4:0] sum_b;
  logic [4:0] diff_imm;
  logic       acc_wr;

  always_comb begin
    acc_d      = acc_q;
    b_d        = b_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    out_data_d = out_data_q;
    out_stb_d  = 1'b0;
    acc_wr     = 1'b0;

    sum_imm  = {1'b0, acc_q} + {1'b0, imm};
    sum_b    = {1'b0, acc_q} + {1'b0, b_q};
    diff_imm = {1'b0, acc_q} - {1'b0, imm};

    if (state && !cf) begin
      unique case (op)
        OP_ADD: begin
          acc_d   = sum_imm[3:0];
          carry_d = sum_imm[4];
          acc_wr  = 1'b1;
        end
        OP_LDI: begin
          acc_d  = imm;
          acc_wr = 1'b1;
        end
        OP_SUB: begin
          acc_d   = diff_imm[3:0];
          carry_d = diff_imm[4];
          acc_wr  = 1'b1;
        end
        OP_MOVB: begin
          b_d = acc_q;
        end
        OP_OUT: begin
          out_data_d = acc_q;
          out_stb_d  = 1'b1;
        end
        OP_AND: begin
          acc_d  = acc_q & imm;
          acc_wr = 1'b1;
        end
        OP_OR: begin
          acc_d  = acc_q | imm;
          acc_wr = 1'b1;
        end
        OP_ADDB: begin
          acc_d   = sum_b[3:0];
          carry_d = sum_b[4];
          acc_wr  = 1'b1;
        end
        default: ;
      endcase
    end

    // The zero flag follows only instructions that write the accumulator.
    if (acc_wr) begin
      zero_d = (acc_d == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= 4'd0;
      b_q        <= 4'd0;
      zero_q     <= 1'b1;
      carry_q    <= 1'b0;
      out_data_q <= 4'd0;
      out_stb_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      b_q        <= b_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      out_data_q <= out_data_d;
      out_stb_q  <= out_stb_d;
    end
  end

  // The status word comes straight from the flag registers. It has no
  // bypass, so flags written at an edge appear here in the following cycle.
  logic [3:0] status;
  logic       drive_en;

  always_comb begin
    status            = 4'd0;
    status[ZERO_BIT]  = zero_q;
    status[CARRY_BIT] = carry_q;
  end

  // rst gates the driver so the bus is released as soon as reset asserts.
  assign drive_en = rst && state && cf;
  assign bus      = drive_en ? status : 4'bzzzz;

  assign acc      = acc_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign out_data = out_data_q;
  assign out_stb  = out_stb_q;

endmodule

// File: tb/tb_datapath_unit.sv
`timescale 1ns/1ps
module tb_datapath_unit;

  logic       clk;
  logic       rst;
  logic       state;
  logic [7:0] instr;
  wire  [3:0] bus;
  logic [3:0] acc;
  logic       zero;
  logic       carry;
  logic [3:0] out_data;
  logic       out_stb;

  // Another bus master that uses the bus whenever the datapath must be off it.
  logic       tb_drv_en;
  logic [3:0] tb_drv;
  assign bus = tb_drv_en ? tb_drv : 4'bzzzz;

  datapath_unit #(.ZERO_BIT(0), .CARRY_BIT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .instr    (instr),
    .bus      (bus),
    .acc      (acc),
    .zero     (zero),
    .carry    (carry),
    .out_data (out_data),
    .out_stb  (out_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] acc;
    logic       zero;
    logic       carry;
    logic [3:0] out_data;
    logic       out_stb;
    logic [3:0] bus;
    logic [7:0] instr;
  } exp_t;

  exp_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural reference model using integer arithmetic.
  int m_acc, m_b, m_out;
  bit m_zero, m_carry, m_stb;

  function automatic void model_reset();
    m_acc   = 0;
    m_b     = 0;
    m_out   = 0;
    m_zero  = 1'b1;
    m_carry = 1'b0;
    m_stb   = 1'b0;
  endfunction

  function automatic void model_exec(input bit st, input logic [7:0] ins);
    int imm;
    int op;
    int s;
    imm   = int'(ins[3:0]);
    op    = int'(ins[7]) * 4 + int'(ins[6:5]);
    m_stb = 1'b0;
    if (st && !ins[4]) begin
      case (op)
        0: begin s = m_acc + imm; m_carry = (s > 15); m_acc = s % 16; m_zero = (m_acc == 0); end
        1: begin m_acc = imm; m_zero = (m_acc == 0); end
        2: begin m_carry = (imm > m_acc); m_acc = (m_acc - imm + 16) % 16; m_zero = (m_acc == 0); end
        3: m_b = m_acc;
        4: begin m_out = m_acc; m_stb = 1'b1; end
        5: begin m_acc = m_acc & imm; m_zero = (m_acc == 0); end
        6: begin m_acc = m_acc | imm; m_zero = (m_acc == 0); end
        default: begin s = m_acc + m_b; m_carry = (s > 15); m_acc = s % 16; m_zero = (m_acc == 0); end
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One instruction cycle. It is called just after a rising edge. It pushes
  // the values that should be visible during this cycle, then advances the
  // model across the next edge.
  task automatic step(input bit st, input logic [7:0] ins);
    exp_t e;
    state = st;
    instr = ins;
    e.acc      = 4'(m_acc);
    e.zero     = m_zero;
    e.carry    = m_carry;
    e.out_data = 4'(m_out);
    e.out_stb  = m_stb;
    e.instr    = ins;
    if (st && ins[4]) begin
      tb_drv_en = 1'b0;
      e.bus     = {2'b00, m_carry, m_zero};
    end else begin
      tb_drv_en = 1'b1;
      tb_drv    = 4'($urandom_range(0, 15));
      e.bus     = tb_drv;
    end
    exp_q.push_back(e);
    model_exec(st, ins);
    @(posedge clk);
    #1;
  endtask

  // Monitor: check whatever the DUT presents mid-cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("acc[%h]", e.instr), acc, e.acc);
        chk($sformatf("zero[%h]", e.instr), {3'b0, zero}, {3'b0, e.zero});
        chk($sformatf("carry[%h]", e.instr), {3'b0, carry}, {3'b0, e.carry});
        chk($sformatf("out_data[%h]", e.instr), out_data, e.out_data);
        chk($sformatf("out_stb[%h]", e.instr), {3'b0, out_stb}, {3'b0, e.out_stb});
        chk($sformatf("bus[%h]", e.instr), bus, e.bus);
      end
    end
  end

  task automatic reset_mid_cycle();
    state     = 1'b1;
    instr     = 8'h25;          // LDI 5
    tb_drv_en = 1'b1;
    tb_drv    = 4'b1010;
    #2 rst = 1'b0;
    #1;
    chk("rst_acc", acc, 4'd0);
    chk("rst_zero", {3'b0, zero}, 4'd1);
    chk("rst_carry", {3'b0, carry}, 4'd0);
    chk("rst_out_data", out_data, 4'd0);
    chk("rst_out_stb", {3'b0, out_stb}, 4'd0);
    instr  = 8'h33;             // JNZ: the datapath must still be off the bus
    tb_drv = 4'b0110;
    #0.5;
    chk("rst_bus", bus, 4'b0110);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int budget;
    rst       = 1'b0;
    state     = 1'b0;
    instr     = 8'h00;
    tb_drv_en = 1'b1;
    tb_drv    = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Arithmetic chain: LDI 9, SUB 2, ADD 12
    step(1, 8'h29); step(1, 8'h42); step(1, 8'h0C);
    // Borrow and zero: LDI 3, SUB 3, JNZ (status), SUB 1, JNZ with state=0
    step(1, 8'h23); step(1, 8'h43); step(1, 8'h33); step(1, 8'h41);
    step(1, 8'h33); step(0, 8'h33); step(1, 8'h33);
    // B path and output: LDI 6, MOVB, LDI 11, ADDB, OUT, then a non-OUT
    step(1, 8'h26); step(1, 8'h60); step(1, 8'h2B); step(1, 8'hE0);
    step(1, 8'h80); step(1, 8'h33); step(1, 8'h80); step(1, 8'h80);
    // Hold: state=0 with ADD 1 for five cycles
    for (int i = 0; i < 5; i++) step(0, 8'h01);
    step(1, 8'h33);
    // AND / OR
    step(1, 8'h2F); step(1, 8'hA5); step(1, 8'hC8); step(1, 8'hA0);
    // Reset in the middle of a program, with out_stb high beforehand
    step(1, 8'h27); step(1, 8'h80);
    reset_mid_cycle();
    step(1, 8'h33); step(1, 8'h0F); step(1, 8'h01); step(1, 8'h33);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 8'($urandom_range(0, 255)));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    n_assert++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
